// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline boundary with a 2-entry skid FIFO.
// Each accepted instruction is decoded at push time. The decode produces the aligned address,
// the byte offset, the load/store byte-lane masks, the lane-shifted store data and a trap flag.
// These results are stored next to alu_res and the opaque payload. The outputs always show the
// head entry.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   flush             drop every held entry (wins over push/pop)
//   in_valid/in_ready upstream handshake; in_ready comes from registered occupancy only
//   opcode, funct3    instruction fields used for decode
//   alu_res           effective address / ALU result
//   store_data        raw store operand
//   payload_in/out    sideband carried unmodified
//   out_valid/ready   downstream handshake
//   addr_aligned      alu_res with the byte-offset bits cleared
//   alu_res_out       alu_res as captured
//   byte_off          low address bits inside one XLEN word
//   wmask, rmask      byte-lane masks (zero when trapping or not a memory access)
//   wdata             store data shifted onto its byte lanes
//   trap              illegal opcode/funct3 or misaligned access
module ex_mem_stage #(
  parameter int unsigned XLEN             = 32,
  parameter int unsigned PAYLOAD_W        = 128,
  parameter int unsigned ALLOW_MISALIGNED = 0,
  localparam int unsigned NB              = XLEN / 8,
  localparam int unsigned OW              = $clog2(NB)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [XLEN-1:0]      alu_res,
  input  logic [XLEN-1:0]      store_data,
  input  logic [PAYLOAD_W-1:0] payload_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      addr_aligned,
  output logic [XLEN-1:0]      alu_res_out,
  output logic [OW-1:0]        byte_off,
  output logic [NB-1:0]        wmask,
  output logic [NB-1:0]        rmask,
  output logic [XLEN-1:0]      wdata,
  output logic                 trap,
  output logic [PAYLOAD_W-1:0] payload_out
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [1:0] {SzB, SzH, SzW, SzD} size_e;

  typedef struct packed {
    logic [XLEN-1:0]      addr_aligned;
    logic [XLEN-1:0]      alu_res;
    logic [OW-1:0]        byte_off;
    logic [NB-1:0]        wmask;
    logic [NB-1:0]        rmask;
    logic [XLEN-1:0]      wdata;
    logic                 trap;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Decode of the incoming instruction
  // ---------------------------------------------------------------------------
  size_e           size;
  logic            mem_acc;
  logic            is_store;
  logic            legal;
  logic            misal;
  logic            trap_c;
  logic [OW-1:0]   off;
  logic [NB-1:0]   base_mask;
  logic [NB-1:0]   acc_mask;
  logic [NB-1:0]   wmask_c;
  logic [NB-1:0]   rmask_c;
  logic [XLEN-1:0] wdata_c;
  logic [XLEN-1:0] addr_c;
  entry_t          new_entry;

  assign off = alu_res[OW-1:0];

  always_comb begin
    mem_acc  = 1'b0;
    is_store = 1'b0;
    legal    = 1'b0;
    size     = SzB;
    case (opcode)
      OpLoad: begin
        mem_acc = 1'b1;
        case (funct3)
          3'b000, 3'b100: begin size = SzB; legal = 1'b1;         end
          3'b001, 3'b101: begin size = SzH; legal = 1'b1;         end
          3'b010:         begin size = SzW; legal = 1'b1;         end
          3'b110:         begin size = SzW; legal = (XLEN == 64); end  // lwu
          3'b011:         begin size = SzD; legal = (XLEN == 64); end  // ld
          default:        legal = 1'b0;
        endcase
      end
      OpStore: begin
        mem_acc  = 1'b1;
        is_store = 1'b1;
        case (funct3)
          3'b000:  begin size = SzB; legal = 1'b1;         end
          3'b001:  begin size = SzH; legal = 1'b1;         end
          3'b010:  begin size = SzW; legal = 1'b1;         end
          3'b011:  begin size = SzD; legal = (XLEN == 64); end
          default: legal = 1'b0;
        endcase
      end
      // funct3 010/011 are the only unassigned branch encodings
      OpBranch: legal = (funct3[2:1] != 2'b01);
      OpLui, OpAuipc, OpImm, OpReg, OpJal, OpJalr: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    misal = 1'b0;
    if (ALLOW_MISALIGNED == 0) begin
      case (size)
        SzH:     misal = off[0];
        SzW:     misal = |off[1:0];
        SzD:     misal = |off;
        default: misal = 1'b0;
      endcase
    end
  end

  assign trap_c = ~legal | (mem_acc & misal);

  always_comb begin
    base_mask = '0;
    case (size)
      SzB:     base_mask[0]   = 1'b1;
      SzH:     base_mask[1:0] = 2'b11;
      SzW:     base_mask[3:0] = 4'hF;
      default: base_mask      = '1;
    endcase
  end

  // Lanes shifted past the word are dropped by the NB-bit result width.
  // Double accesses cover the full word and are never shifted.
  assign acc_mask = (size == SzD) ? base_mask : (base_mask << off);
  assign wmask_c  = (mem_acc &  is_store & ~trap_c) ? acc_mask : '0;
  assign rmask_c  = (mem_acc & ~is_store & ~trap_c) ? acc_mask : '0;
  assign wdata_c  = is_store ? (store_data << {off, 3'b000}) : store_data;
  assign addr_c   = {alu_res[XLEN-1:OW], {OW{1'b0}}};

  always_comb begin
    new_entry              = '0;
    new_entry.addr_aligned = addr_c;
    new_entry.alu_res      = alu_res;
    new_entry.byte_off     = off;
    new_entry.wmask        = wmask_c;
    new_entry.rmask        = rmask_c;
    new_entry.wdata        = wdata_c;
    new_entry.trap         = trap_c;
    new_entry.payload      = payload_in;
  end

  // ---------------------------------------------------------------------------
  // 2-entry FIFO
  // ---------------------------------------------------------------------------
  entry_t     mem_q [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       push;
  logic       pop;
  entry_t     head;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      cnt_d    = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (push && !flush) mem_q[wr_ptr_q] <= new_entry;
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign addr_aligned = head.addr_aligned;
  assign alu_res_out  = head.alu_res;
  assign byte_off     = head.byte_off;
  assign wmask        = head.wmask;
  assign rmask        = head.rmask;
  assign wdata        = head.wdata;
  assign trap         = head.trap;
  assign payload_out  = head.payload;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage. Three instances share one handshake stream:
// d0 = XLEN 32, strict alignment; d1 = XLEN 32, misaligned allowed; d2 = XLEN 64, strict.
// A queue-based reference model decodes each accepted input from the access rules.
module tb_ex_mem_stage;

  typedef struct packed {
    logic [63:0]  addr;
    logic [63:0]  alu;
    logic [2:0]   boff;
    logic [7:0]   wmask;
    logic [7:0]   rmask;
    logic [63:0]  wdata;
    logic         trap;
    logic [127:0] pl;
  } exp_t;
  typedef exp_t [2:0] trip_t;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, out_ready;
  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic [63:0]  alu_res, store_data;
  logic [127:0] payload_in;

  logic [2:0]   out_valid_w, in_ready_w;
  logic [31:0]  addr0, alu0, wd0, addr1, alu1, wd1;
  logic [63:0]  addr2, alu2, wd2;
  logic [1:0]   boff0, boff1;
  logic [2:0]   boff2;
  logic [3:0]   wm0, rm0, wm1, rm1;
  logic [7:0]   wm2, rm2;
  logic         trap0, trap1, trap2;
  logic [127:0] pl0, pl1, pl2;

  always #5 clk = ~clk;

  ex_mem_stage #(.XLEN(32), .PAYLOAD_W(128), .ALLOW_MISALIGNED(0)) u_d0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .opcode(opcode), .funct3(funct3), .alu_res(alu_res[31:0]), .store_data(store_data[31:0]),
    .payload_in(payload_in), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .addr_aligned(addr0), .alu_res_out(alu0), .byte_off(boff0), .wmask(wm0), .rmask(rm0),
    .wdata(wd0), .trap(trap0), .payload_out(pl0)
  );

  ex_mem_stage #(.XLEN(32), .PAYLOAD_W(128), .ALLOW_MISALIGNED(1)) u_d1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .opcode(opcode), .funct3(funct3), .alu_res(alu_res[31:0]), .store_data(store_data[31:0]),
    .payload_in(payload_in), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .addr_aligned(addr1), .alu_res_out(alu1), .byte_off(boff1), .wmask(wm1), .rmask(rm1),
    .wdata(wd1), .trap(trap1), .payload_out(pl1)
  );

  ex_mem_stage #(.XLEN(64), .PAYLOAD_W(128), .ALLOW_MISALIGNED(0)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .opcode(opcode), .funct3(funct3), .alu_res(alu_res), .store_data(store_data),
    .payload_in(payload_in), .out_valid(out_valid_w[2]), .out_ready(out_ready),
    .addr_aligned(addr2), .alu_res_out(alu2), .byte_off(boff2), .wmask(wm2), .rmask(rm2),
    .wdata(wd2), .trap(trap2), .payload_out(pl2)
  );

  int    n_checks = 0;
  int    n_pass   = 0;
  trip_t q[$];
  bit    zero_flag = 1'b1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference decode from the access rules: size in bytes, legality, alignment by modulo.
  function automatic exp_t model(input int xlen, input bit allow, input logic [6:0] op,
                                 input logic [2:0] f3, input logic [63:0] alu,
                                 input logic [63:0] sd, input logic [127:0] pl);
    exp_t        e;
    int          nb    = xlen / 8;
    int          off   = int'(alu[2:0]) % nb;
    int          bytes = 0;
    bit          ld = 0, st = 0, legal = 0, misal = 0;
    logic [7:0]  m = 8'h0;
    logic [63:0] xm = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    int          mi;
    case (op)
      7'h03: begin
        ld = 1;
        case (f3)
          3'd0, 3'd4: bytes = 1;
          3'd1, 3'd5: bytes = 2;
          3'd2:       bytes = 4;
          3'd6:       bytes = (xlen == 64) ? 4 : 0;
          3'd3:       bytes = (xlen == 64) ? 8 : 0;
          default:    bytes = 0;
        endcase
        legal = (bytes != 0);
      end
      7'h23: begin
        st = 1;
        case (f3)
          3'd0:    bytes = 1;
          3'd1:    bytes = 2;
          3'd2:    bytes = 4;
          3'd3:    bytes = (xlen == 64) ? 8 : 0;
          default: bytes = 0;
        endcase
        legal = (bytes != 0);
      end
      7'h63: legal = !(f3 == 3'd2 || f3 == 3'd3);
      7'h37, 7'h17, 7'h13, 7'h33, 7'h6f, 7'h67: legal = 1;
      default: legal = 0;
    endcase
    if (bytes != 0 && !allow) misal = (off % bytes) != 0;
    e.trap = !legal || ((ld || st) && misal);
    if ((ld || st) && !e.trap) begin
      if (bytes == 8) m = 8'hFF;
      else begin
        mi = ((1 << bytes) - 1) << off;
        m  = 8'(mi & ((1 << nb) - 1));
      end
    end
    e.wmask = st ? m : 8'h0;
    e.rmask = ld ? m : 8'h0;
    e.wdata = st ? ((sd << (8 * off)) & xm) : (sd & xm);
    e.addr  = alu & xm & ~64'(nb - 1);
    e.alu   = alu & xm;
    e.boff  = 3'(off);
    e.pl    = pl;
    return e;
  endfunction

  function automatic exp_t observe(input int k);
    exp_t e;
    case (k)
      0: begin
        e.addr = {32'h0, addr0}; e.alu = {32'h0, alu0}; e.boff = {1'b0, boff0};
        e.wmask = {4'h0, wm0}; e.rmask = {4'h0, rm0}; e.wdata = {32'h0, wd0};
        e.trap = trap0; e.pl = pl0;
      end
      1: begin
        e.addr = {32'h0, addr1}; e.alu = {32'h0, alu1}; e.boff = {1'b0, boff1};
        e.wmask = {4'h0, wm1}; e.rmask = {4'h0, rm1}; e.wdata = {32'h0, wd1};
        e.trap = trap1; e.pl = pl1;
      end
      default: begin
        e.addr = addr2; e.alu = alu2; e.boff = boff2; e.wmask = wm2; e.rmask = rm2;
        e.wdata = wd2; e.trap = trap2; e.pl = pl2;
      end
    endcase
    return e;
  endfunction

  task automatic model_step();
    bit    push, pop;
    trip_t t;
    if (!rst) begin
      q.delete();
      zero_flag = 1'b1;
    end else if (flush) begin
      q.delete();
    end else begin
      push = in_valid && (q.size() < 2);
      pop  = (q.size() > 0) && out_ready;
      if (pop) void'(q.pop_front());
      if (push) begin
        t[0] = model(32, 1'b0, opcode, funct3, alu_res, store_data, payload_in);
        t[1] = model(32, 1'b1, opcode, funct3, alu_res, store_data, payload_in);
        t[2] = model(64, 1'b0, opcode, funct3, alu_res, store_data, payload_in);
        q.push_back(t);
        zero_flag = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    exp_t got, exp;
    for (int k = 0; k < 3; k++) begin
      got = observe(k);
      check_eq($sformatf("d%0d out_valid", k), 128'(out_valid_w[k]), 128'(q.size() > 0));
      check_eq($sformatf("d%0d in_ready", k), 128'(in_ready_w[k]), 128'(q.size() < 2));
      if (q.size() > 0 || zero_flag) begin
        exp = (q.size() > 0) ? q[0][k] : '0;
        check_eq($sformatf("d%0d addr_aligned", k), 128'(got.addr), 128'(exp.addr));
        check_eq($sformatf("d%0d alu_res_out", k), 128'(got.alu), 128'(exp.alu));
        check_eq($sformatf("d%0d byte_off", k), 128'(got.boff), 128'(exp.boff));
        check_eq($sformatf("d%0d wmask", k), 128'(got.wmask), 128'(exp.wmask));
        check_eq($sformatf("d%0d rmask", k), 128'(got.rmask), 128'(exp.rmask));
        check_eq($sformatf("d%0d wdata", k), 128'(got.wdata), 128'(exp.wdata));
        check_eq($sformatf("d%0d trap", k), 128'(got.trap), 128'(exp.trap));
        check_eq($sformatf("d%0d payload", k), got.pl, exp.pl);
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check 1 time unit later.
  task automatic cyc(input bit r, input bit f, input bit iv, input bit ordy,
                     input logic [6:0] op, input logic [2:0] f3,
                     input logic [63:0] alu, input logic [63:0] sdat);
    rst        = r;
    flush      = f;
    in_valid   = iv;
    out_ready  = ordy;
    opcode     = op;
    funct3     = f3;
    alu_res    = alu;
    store_data = sdat;
    payload_in = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  logic [6:0] ops [9] = '{7'h03, 7'h23, 7'h37, 7'h17, 7'h13, 7'h33, 7'h6f, 7'h67, 7'h63};

  initial begin
    cyc(0, 0, 0, 0, 7'h13, 3'd0, 64'h0, 64'h0);
    cyc(0, 0, 1, 1, 7'h13, 3'd0, 64'h0, 64'h0);

    // sh to offset 2
    cyc(1, 0, 1, 1, 7'h23, 3'd1, 64'h1002, 64'h0000_ABCD);
    check_eq("sh out_valid", 128'(out_valid_w[0]), 128'd1);
    check_eq("sh addr_aligned", 128'(addr0), 128'h1000);
    check_eq("sh byte_off", 128'(boff0), 128'd2);
    check_eq("sh wmask", 128'(wm0), 128'hC);
    check_eq("sh wdata", 128'(wd0), 128'hABCD_0000);
    check_eq("sh trap", 128'(trap0), 128'd0);

    // misaligned lw
    cyc(1, 0, 1, 1, 7'h03, 3'd2, 64'h1001, 64'h0);
    check_eq("lw strict trap", 128'(trap0), 128'd1);
    check_eq("lw strict rmask", 128'(rm0), 128'd0);
    check_eq("lw loose trap", 128'(trap1), 128'd0);
    check_eq("lw loose rmask", 128'(rm1), 128'hE);

    // sd on both widths
    cyc(1, 0, 1, 1, 7'h23, 3'd3, 64'h2000, 64'h1122_3344_5566_7788);
    check_eq("sd64 wmask", 128'(wm2), 128'hFF);
    check_eq("sd32 trap", 128'(trap0), 128'd1);
    check_eq("sd32 wmask", 128'(wm0), 128'd0);
    cyc(1, 0, 0, 1, 7'h13, 3'd0, 64'h0, 64'h0);

    // backpressure: A then B held, third input refused
    cyc(1, 0, 1, 0, 7'h13, 3'd0, 64'hA0, 64'h0);
    cyc(1, 0, 1, 0, 7'h13, 3'd0, 64'hB0, 64'h0);
    check_eq("full in_ready", 128'(in_ready_w[0]), 128'd0);
    check_eq("full head A", 128'(alu0), 128'hA0);
    cyc(1, 0, 1, 0, 7'h13, 3'd0, 64'hC0, 64'h0);
    check_eq("stall head A", 128'(alu0), 128'hA0);
    cyc(1, 0, 0, 1, 7'h13, 3'd0, 64'h0, 64'h0);
    check_eq("pop head B", 128'(alu0), 128'hB0);
    check_eq("pop in_ready", 128'(in_ready_w[0]), 128'd1);
    cyc(1, 0, 0, 1, 7'h13, 3'd0, 64'h0, 64'h0);
    check_eq("drained", 128'(out_valid_w[0]), 128'd0);

    // flush while full with a pending input
    cyc(1, 0, 1, 0, 7'h13, 3'd0, 64'h11, 64'h0);
    cyc(1, 0, 1, 0, 7'h13, 3'd0, 64'h22, 64'h0);
    cyc(1, 1, 1, 0, 7'h13, 3'd0, 64'h33, 64'h0);
    check_eq("flush out_valid", 128'(out_valid_w[0]), 128'd0);
    cyc(1, 0, 0, 0, 7'h13, 3'd0, 64'h0, 64'h0);
    check_eq("flush no capture", 128'(out_valid_w[0]), 128'd0);

    // reset while full
    cyc(1, 0, 1, 0, 7'h03, 3'd0, 64'h45, 64'h0);
    cyc(1, 0, 1, 0, 7'h23, 3'd0, 64'h47, 64'h99);
    cyc(0, 0, 1, 1, 7'h13, 3'd0, 64'h55, 64'h0);
    check_eq("rst out_valid", 128'(out_valid_w[2]), 128'd0);
    check_eq("rst in_ready", 128'(in_ready_w[2]), 128'd1);
    check_eq("rst alu_res_out", 128'(alu2), 128'd0);
    check_eq("rst payload", pl0, 128'd0);

    for (int i = 0; i < 1500; i++) begin
      logic [6:0] op;
      op = ($urandom_range(9, 0) == 9) ? 7'($urandom) : ops[$urandom_range(8, 0)];
      cyc($urandom_range(99, 0) != 0, $urandom_range(29, 0) == 0, $urandom_range(9, 0) < 7,
          $urandom_range(9, 0) < 6, op, 3'($urandom), {$urandom, $urandom},
          {$urandom, $urandom});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
